// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo
//   Receive-side FWFT buffer behind the SPI master. Every completed frame
//   (spi_done strobe + spi_rdata) is pushed into a register-array FIFO that
//   sys_clk consumers drain with rd_en. Frame/drop statistics and a sticky
//   overflow flag are kept for the control path.
//
// Ports
//   sys_clk, sys_rst_n : clock, async active-low reset
//   spi_done/spi_rdata : frame strobe and data from the SPI master (write side)
//   flush              : synchronous clear of the FIFO contents
//   rd_en              : pop head entry
//   rd_data/rd_valid   : head entry (0 while empty) / FIFO non-empty
//   full/almost_full   : level == DEPTH / level >= AF_LEVEL
//   level              : number of stored entries
//   ovf/ovf_clr        : sticky overflow flag and its clear
//   drop_cnt           : dropped-frame count, saturating at 255
//   frame_cnt          : spi_done pulse count, wrapping
module spi_rx_fifo #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       spi_done,
    input  logic [DATA_W-1:0]          spi_rdata,
    input  logic                       flush,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    input  logic                       ovf_clr,
    output logic [7:0]                 drop_cnt,
    output logic [15:0]                frame_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wp, rp;
    logic              empty;
    logic              do_wr, do_rd, drop;

    // Pointers carry a wrap bit: equal low bits with differing wrap bits
    // means the write side has lapped the read side exactly once.
    assign empty       = (wp == rp);
    assign full        = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    assign level       = wp - rp;
    assign rd_valid    = !empty;
    assign almost_full = (level >= AF_LVL);
    assign rd_data     = rd_valid ? mem[rp[AW-1:0]] : '0;

    // A write into a full FIFO is allowed when the same cycle pops, since
    // the freed slot is the one being written. Flush discards any frame
    // arriving in the same cycle without counting it as a drop.
    assign do_rd = rd_en && rd_valid && !flush;
    assign do_wr = spi_done && !flush && (!full || rd_en);
    assign drop  = spi_done && !flush && full && !rd_en;

    always_ff @(posedge sys_clk) begin
        if (do_wr)
            mem[wp[AW-1:0]] <= spi_rdata;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wp        <= '0;
            rp        <= '0;
            ovf       <= 1'b0;
            drop_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            if (do_wr)
                wp <= wp + PTR_ONE;

            if (flush)
                rp <= wp;
            else if (do_rd)
                rp <= rp + PTR_ONE;

            // Set has priority over clear so a drop is never lost.
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;

            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;

            if (spi_done)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Scoreboard bench for spi_rx_fifo: stimulus pushes expected words, a
// negedge monitor pops and compares whenever a pop is presented.
module tb_spi_rx_fifo;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rdata = '0;
    logic        flush = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        almost_full;
    logic [4:0]  level;
    logic        ovf;
    logic        ovf_clr = 1'b0;
    logic [7:0]  drop_cnt;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    spi_rx_fifo #(.DATA_W(16), .DEPTH(16), .AF_LEVEL(12)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .spi_done(spi_done), .spi_rdata(spi_rdata),
        .flush(flush), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .almost_full(almost_full), .level(level),
        .ovf(ovf), .ovf_clr(ovf_clr),
        .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs are stable at the negedge, so a pop presented here is
    // the one the next posedge performs.
    always @(negedge sys_clk) begin
        if (sys_rst_n && rd_en && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no data", rd_data);
            end else begin
                chk("pop_data", {16'h0, rd_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // One clock of stimulus; inputs return to idle afterwards.
    task automatic step(input logic d, input logic [15:0] w, input logic rd,
                        input logic fl, input logic clr);
        spi_done = d; spi_rdata = w; rd_en = rd; flush = fl; ovf_clr = clr;
        @(posedge sys_clk); #1;
        spi_done = 0; spi_rdata = '0; rd_en = 0; flush = 0; ovf_clr = 0;
    endtask

    task automatic push(input logic [15:0] w);
        exp_q.push_back(w);
        step(1, w, 0, 0, 0);
    endtask

    task automatic pop();
        step(0, 16'h0, 1, 0, 0);
    endtask

    // Assert reset, check that every output is at its reset value in that
    // same cycle, then release mid-cycle.
    task automatic do_reset(input string tag);
        sys_rst_n = 0;
        #1;
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_afull"}, almost_full, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_drop"}, drop_cnt, 0);
        chk({tag, "_frame"}, frame_cnt, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        exp_q.delete();
        @(negedge sys_clk);
        sys_rst_n = 1;
        @(posedge sys_clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic ordering
        do_reset("rst0");
        push(16'hA5A5); push(16'h1234); push(16'hFFFF);
        chk("t1_level", level, 3);
        chk("t1_head", rd_data, 16'hA5A5);
        chk("t1_frame", frame_cnt, 3);
        pop(); pop(); pop();
        chk("t1_empty_valid", rd_valid, 0);
        chk("t1_empty_data", rd_data, 0);
        pop(); // read while empty: ignored
        chk("t1_rd_empty_level", level, 0);

        // Fill, almost_full threshold, drop on full
        do_reset("rst1");
        for (int i = 0; i < 16; i++) begin
            push(16'(i));
            if (i == 10) chk("t2_afull_11", almost_full, 0);
            if (i == 11) chk("t2_afull_12", almost_full, 1);
        end
        chk("t2_full", full, 1);
        chk("t2_ovf_pre", ovf, 0);
        step(1, 16'hDEAD, 0, 0, 0);
        chk("t2_ovf", ovf, 1);
        chk("t2_drop", drop_cnt, 1);
        chk("t2_frame", frame_cnt, 17);
        chk("t2_level", level, 16);

        // Write with simultaneous pop while full: accepted
        exp_q.push_back(16'hBEEF);
        step(1, 16'hBEEF, 1, 0, 0);
        chk("t3_level", level, 16);
        chk("t3_ovf", ovf, 1);
        chk("t3_drop", drop_cnt, 1);
        for (int i = 0; i < 16; i++) pop();
        chk("t3_drained", rd_valid, 0);

        // Drop saturation and ovf set/clear priority
        do_reset("rst2");
        for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
        for (int i = 0; i < 300; i++) step(1, 16'(i), 0, 0, 0);
        chk("t4_drop_sat", drop_cnt, 255);
        step(1, 16'h9999, 0, 0, 1);
        chk("t4_ovf_set_wins", ovf, 1);
        step(0, 16'h0, 0, 0, 1);
        chk("t4_ovf_clr", ovf, 0);
        chk("t4_drop_kept", drop_cnt, 255);
        chk("t4_frame", frame_cnt, 317);
        for (int i = 0; i < 16; i++) pop();

        // Flush with coincident frame
        do_reset("rst3");
        for (int i = 0; i < 5; i++) push(16'h0200 + 16'(i));
        chk("t5_level5", level, 5);
        exp_q.delete();
        step(1, 16'h7777, 0, 1, 0);
        chk("t5_level0", level, 0);
        chk("t5_valid", rd_valid, 0);
        chk("t5_drop", drop_cnt, 0);
        chk("t5_ovf", ovf, 0);
        chk("t5_frame", frame_cnt, 6);
        push(16'h5555);
        chk("t5_head", rd_data, 16'h5555);
        pop();

        // Streaming write+read every cycle, pointers wrap past 32
        do_reset("rst4");
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(16'h0300 + 16'(i));
            step(1, 16'h0300 + 16'(i), 1, 0, 0);
            chk("t6_level1", level, 1);
        end
        pop();
        chk("t6_empty", rd_valid, 0);
        chk("t6_frame", frame_cnt, 40);

        // Reset mid-stream from a full/overflowed state
        for (int i = 0; i < 16; i++) push(16'h0400 + 16'(i));
        step(1, 16'hBAD0, 0, 0, 0);
        chk("t7_pre_ovf", ovf, 1);
        do_reset("rst_mid");
        push(16'h4242);
        chk("t7_after_level", level, 1);
        chk("t7_after_frame", frame_cnt, 1);
        pop();

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
